// File: rtl/pacman_motion_controller.sv
// Pacman position and game-phase controller: steps the sprite once per video frame
// from synchronized buttons, honouring wall-collision and coin-completion flags.
module pacman_motion_controller #(
  parameter int START_X     = 310,
  parameter int START_Y     = 230,
  parameter int SPRITE_SIZE = 22,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int STEP        = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_end,
  input  logic       BTNU,
  input  logic       BTND,
  input  logic       BTNL,
  input  logic       BTNR,
  input  logic       BTNC,
  input  logic       canNotMove,
  input  logic       isDoneCollecting,
  output logic [9:0] pacman_x,
  output logic [8:0] pacman_y,
  output logic [2:0] direction,
  output logic [1:0] game_state,
  output logic       show_title,
  output logic       move_pulse
);

  typedef enum logic [1:0] {TITLE = 2'd0, PLAY = 2'd1, WON = 2'd2} state_t;
  typedef enum logic [2:0] {NONE = 3'd0, UP = 3'd1, DOWN = 3'd2, LEFT = 3'd3, RIGHT = 3'd4} dir_t;

  localparam logic [10:0] MAX_X = 11'(SCREEN_W - SPRITE_SIZE);
  localparam logic [10:0] MAX_Y = 11'(SCREEN_H - SPRITE_SIZE);
  localparam logic [10:0] STEP_W = 11'(STEP);

  // Bit order: {frame_end, BTNC, BTNR, BTNL, BTND, BTNU}
  logic [5:0] r_sync1, r_sync2;
  logic       r_frameDly, r_startDly;
  state_t     r_state, w_nextState;
  dir_t       r_dir, w_nextDir;
  logic [9:0] r_x, w_nextX;
  logic [8:0] r_y, w_nextY;
  logic       r_showTitle, r_movePulse, w_nextPulse;
  logic       w_tick, w_start;
  logic [10:0] w_xExt, w_yExt, w_candX, w_candY;

  assign w_tick  = r_sync2[5] & ~r_frameDly;
  assign w_start = r_sync2[4] & ~r_startDly;
  assign w_xExt  = {1'b0, r_x};
  assign w_yExt  = {2'b0, r_y};

  // Candidate position uses the direction registered before this cycle, saturated to the screen.
  always_comb begin
    w_candX = w_xExt;
    w_candY = w_yExt;
    case (r_dir)
      UP:      w_candY = (w_yExt < STEP_W) ? 11'd0 : w_yExt - STEP_W;
      DOWN:    w_candY = (w_yExt + STEP_W > MAX_Y) ? MAX_Y : w_yExt + STEP_W;
      LEFT:    w_candX = (w_xExt < STEP_W) ? 11'd0 : w_xExt - STEP_W;
      RIGHT:   w_candX = (w_xExt + STEP_W > MAX_X) ? MAX_X : w_xExt + STEP_W;
      default: ;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    w_nextDir   = r_dir;
    w_nextX     = r_x;
    w_nextY     = r_y;
    w_nextPulse = 1'b0;
    case (r_state)
      TITLE: begin
        w_nextX   = 10'(START_X);
        w_nextY   = 9'(START_Y);
        w_nextDir = NONE;
        if (w_start) w_nextState = PLAY;
      end
      PLAY: begin
        if (isDoneCollecting) begin
          w_nextState = WON;
          w_nextDir   = NONE;
        end else begin
          if (r_sync2[0])      w_nextDir = UP;
          else if (r_sync2[1]) w_nextDir = DOWN;
          else if (r_sync2[2]) w_nextDir = LEFT;
          else if (r_sync2[3]) w_nextDir = RIGHT;
          if (w_tick && r_dir != NONE) begin
            if (canNotMove) begin
              w_nextDir = NONE;
            end else begin
              w_nextX     = w_candX[9:0];
              w_nextY     = w_candY[8:0];
              w_nextPulse = (w_candX[9:0] != r_x) || (w_candY[8:0] != r_y);
            end
          end
        end
      end
      WON: begin
        w_nextDir = NONE;
        if (w_start) begin
          w_nextState = TITLE;
          w_nextX     = 10'(START_X);
          w_nextY     = 9'(START_Y);
        end
      end
      default: w_nextState = TITLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_frameDly  <= 1'b0;
      r_startDly  <= 1'b0;
      r_state     <= TITLE;
      r_dir       <= NONE;
      r_x         <= 10'(START_X);
      r_y         <= 9'(START_Y);
      r_showTitle <= 1'b1;
      r_movePulse <= 1'b0;
    end else begin
      r_sync1     <= {frame_end, BTNC, BTNR, BTNL, BTND, BTNU};
      r_sync2     <= r_sync1;
      r_frameDly  <= r_sync2[5];
      r_startDly  <= r_sync2[4];
      r_state     <= w_nextState;
      r_dir       <= w_nextDir;
      r_x         <= w_nextX;
      r_y         <= w_nextY;
      r_showTitle <= (w_nextState == TITLE);
      r_movePulse <= w_nextPulse;
    end
  end

  assign pacman_x   = r_x;
  assign pacman_y   = r_y;
  assign direction  = r_dir;
  assign game_state = r_state;
  assign show_title = r_showTitle;
  assign move_pulse = r_movePulse;

endmodule
